// File: rtl/csi2_tx_pkg.sv
// Shared constants and state encoding for the CSI-2 TX lane distributor.
package csi2_tx_pkg;

  localparam logic [7:0]  SYNC_BYTE        = 8'hB8;
  localparam int unsigned DATA_LANES_DEF   = 4;
  localparam int unsigned TRAIL_CYCLES_DEF = 2;
  localparam int unsigned EXIT_CYCLES_DEF  = 8;
  localparam int unsigned EXIT_CNT_W       = 8;

  typedef enum logic [2:0] {
    IDLE,
    HS_REQ,
    SYNC,
    DATA,
    TRAIL,
    EXIT
  } tx_state_t;

endpackage

// File: rtl/dphy_tx_lane_trail.sv
// One D-PHY lane: holds the outgoing HS byte, remembers bit 7 of the last
// byte sent and generates the HS trailer once started.
module dphy_tx_lane_trail
  import csi2_tx_pkg::*;
#(
  parameter int unsigned TRAIL_CYCLES = TRAIL_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       start,
  output logic [7:0] hs_data,
  output logic       hs_valid,
  output logic       trail_done_c
);

  localparam int unsigned CNT_W = $clog2(TRAIL_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             last_bit_q;
  logic             trailing_q;
  logic             fin_q;

  // Byte register, trailer counter and completion flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_data    <= '0;
      hs_valid   <= 1'b0;
      cnt_q      <= '0;
      last_bit_q <= 1'b0;
      trailing_q <= 1'b0;
      fin_q      <= 1'b0;
    end else if (load) begin
      hs_data    <= load_byte;
      hs_valid   <= 1'b1;
      last_bit_q <= load_byte[7];
      trailing_q <= 1'b0;
      fin_q      <= 1'b0;
    end else if (start) begin
      hs_data    <= {8{~last_bit_q}};
      hs_valid   <= 1'b1;
      cnt_q      <= CNT_W'(TRAIL_CYCLES - 1);
      trailing_q <= 1'b1;
      fin_q      <= 1'b0;
    end else if (trailing_q) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end else begin
        hs_valid   <= 1'b0;
        trailing_q <= 1'b0;
        fin_q      <= 1'b1;
      end
    end
  end

  // Done while the final trailer byte is on the wire, so the FSM leaves TRAIL
  // at the same edge that drops the last valid.
  assign trail_done_c = fin_q | (trailing_q & (cnt_q == '0));

endmodule

// File: rtl/dphy_tx_lane_dist.sv
// CSI-2 TX lane distributor: requests HS mode, sends SoT sync, stripes packet
// words over the lanes, appends per-lane trailers and holds the HS-exit gap.
module dphy_tx_lane_dist
  import csi2_tx_pkg::*;
#(
  parameter int unsigned DATA_LANES   = DATA_LANES_DEF,
  parameter int unsigned TRAIL_CYCLES = TRAIL_CYCLES_DEF,
  parameter int unsigned EXIT_CYCLES  = EXIT_CYCLES_DEF
) (
  input  logic                       byte_clk_i,
  input  logic                       rst_i,
  input  logic [DATA_LANES-1:0][7:0] word_i,
  input  logic                       valid_i,
  input  logic                       last_i,
  input  logic [DATA_LANES-1:0]      keep_i,
  output logic                       ready_o,
  output logic                       hs_req_o,
  input  logic                       hs_ready_i,
  output logic [DATA_LANES-1:0][7:0] hs_data_o,
  output logic [DATA_LANES-1:0]      hs_valid_o,
  output logic                       underflow_o,
  output logic                       busy_o
);

  localparam logic [EXIT_CNT_W-1:0] EXIT_LAST = EXIT_CNT_W'(EXIT_CYCLES - 1);

  tx_state_t                 state_q, state_d;
  logic [DATA_LANES-1:0]     load, start, done, keep_eff;
  logic [DATA_LANES-1:0]     pend_q, pend_d;
  logic [EXIT_CNT_W-1:0]     exit_q, exit_d;
  logic                      sel_sync;
  logic                      uflow_d;

  // An all-zero keep on the last word still sends lane 0.
  always_comb begin
    keep_eff = (keep_i == '0) ? DATA_LANES'(1) : keep_i;
  end

  // Next state, lane load/start strobes, pending-trailer mask and exit count.
  always_comb begin
    state_d  = state_q;
    load     = '0;
    start    = '0;
    pend_d   = pend_q;
    exit_d   = exit_q;
    sel_sync = 1'b0;
    uflow_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i) state_d = HS_REQ;
      end
      HS_REQ: begin
        if (hs_ready_i) state_d = SYNC;
      end
      SYNC: begin
        load     = '1;
        sel_sync = 1'b1;
        state_d  = DATA;
      end
      DATA: begin
        if (valid_i) begin
          if (last_i) begin
            load    = keep_eff;
            start   = ~keep_eff;
            pend_d  = keep_eff;
            state_d = TRAIL;
          end else begin
            load = '1;
          end
        end else begin
          start   = '1;
          pend_d  = '0;
          uflow_d = 1'b1;
          state_d = TRAIL;
        end
      end
      TRAIL: begin
        start  = pend_q;
        pend_d = '0;
        if (&done) begin
          state_d = EXIT;
          exit_d  = '0;
        end
      end
      EXIT: begin
        if (exit_q == EXIT_LAST) state_d = IDLE;
        else exit_d = exit_q + EXIT_CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered control outputs.
  always_ff @(posedge byte_clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      exit_q      <= '0;
      ready_o     <= 1'b0;
      hs_req_o    <= 1'b0;
      underflow_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      exit_q      <= exit_d;
      ready_o     <= (state_d == DATA);
      hs_req_o    <= (state_d inside {HS_REQ, SYNC, DATA, TRAIL});
      underflow_o <= uflow_d;
      busy_o      <= (state_d != IDLE);
    end
  end

  for (genvar i = 0; i < DATA_LANES; i++) begin : g_lane
    dphy_tx_lane_trail #(
      .TRAIL_CYCLES(TRAIL_CYCLES)
    ) u_lane (
      .clk          (byte_clk_i),
      .rst          (rst_i),
      .load         (load[i]),
      .load_byte    (sel_sync ? SYNC_BYTE : word_i[i]),
      .start        (start[i]),
      .hs_data      (hs_data_o[i]),
      .hs_valid     (hs_valid_o[i]),
      .trail_done_c (done[i])
    );
  end

endmodule
